// File: rtl/fetch_queue.sv
// Instruction fetch queue between IF and ID: an in-order circular buffer of
// {pc, instr} pairs with full back-pressure and a single-cycle flush.
module fetch_queue #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [15:0]   in_pc,
  input  logic [15:0]   in_instr,
  output logic          in_ready,
  output logic          out_valid,
  output logic [15:0]   out_pc,
  output logic [15:0]   out_instr,
  input  logic          out_ready,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high and flush is low; ready never depends on the partner's valid.
  logic [15:0]   pc_mem    [DEPTH];
  logic [15:0]   instr_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push;
  logic          pop;

  // in_ready comes from registered count only, so a full queue refuses a push
  // even when it pops in the same cycle; this keeps out_ready off that path.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);

  assign push = rst_n & in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; empty outputs are forced to NOP below.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : 16'h0000;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : 16'h0000;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random traffic, each cycle
// checked against a queue-based reference model of the fetch buffer.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic [15:0]   in_pc;
  logic [15:0]   in_instr;
  logic          in_ready;
  logic          out_valid;
  logic [15:0]   out_pc;
  logic [15:0]   out_instr;
  logic          out_ready;
  logic [CW-1:0] count;

  logic [31:0] exp_q[$];
  int n_cmp;
  int n_err;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .count     (count)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the queue contents.
  task automatic check_outputs();
    logic [31:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
    chk("count",     32'(count),     32'(exp_q.size()));
    chk("in_ready",  32'(in_ready),  32'(exp_q.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("out_pc",    32'(out_pc),    {16'h0, head[31:16]});
    chk("out_instr", 32'(out_instr), {16'h0, head[15:0]});
  endtask

  // driver: apply one cycle of inputs, check, advance the model and the clock
  task automatic cycle(input logic r, input logic f, input logic iv,
                       input logic [15:0] p, input logic [15:0] ins, input logic ordy);
    bit do_pop;
    bit do_push;
    rst_n     = r;
    flush     = f;
    in_valid  = iv;
    in_pc     = p;
    in_instr  = ins;
    out_ready = ordy;
    #1;
    check_outputs();
    if (!r || f) begin
      exp_q.delete();
    end else begin
      do_pop  = ordy && (exp_q.size() != 0);
      do_push = iv && (exp_q.size() != DEPTH);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({p, ins});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] pc;
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;

    // reset held for 2 cycles, with a push attempt that must be ignored
    cycle(0, 0, 0, 16'h0, 16'h0, 0);
    cycle(0, 0, 1, 16'h0077, 16'h1234, 1);

    // fill to full, 5th push (pc=4) refused
    for (int i = 0; i < 5; i++)
      cycle(1, 0, 1, 16'(i), 16'hA000 + 16'(i), 0);

    // drain in order, then empty with out_ready high
    for (int i = 0; i < 6; i++)
      cycle(1, 0, 0, 16'h0, 16'h0, 1);

    // streaming through several pointer wraps
    for (int i = 0; i < 20; i++)
      cycle(1, 0, 1, 16'h0100 + 16'(i), 16'hB000 + 16'(i), 1);

    // flush under activity from count=3
    while (exp_q.size() < 3)
      cycle(1, 0, 1, 16'h0200 + 16'(exp_q.size()), 16'hC000, 0);
    cycle(1, 1, 1, 16'h0300, 16'hC300, 1);
    cycle(1, 0, 1, 16'h0040, 16'hD040, 0);
    cycle(1, 0, 0, 16'h0, 16'h0, 0);

    // full with simultaneous pop: pop taken, push refused
    while (exp_q.size() < DEPTH)
      cycle(1, 0, 1, 16'h0500 + 16'(exp_q.size()), 16'hE000, 0);
    cycle(1, 0, 1, 16'h0600, 16'hE600, 1);
    cycle(1, 0, 0, 16'h0, 16'h0, 0);

    // reset mid-stream at count=2 with a push, then reset plus flush together
    cycle(1, 0, 0, 16'h0, 16'h0, 1);
    cycle(0, 0, 1, 16'h0700, 16'hF700, 0);
    cycle(1, 0, 0, 16'h0, 16'h0, 1);
    cycle(1, 0, 1, 16'h0800, 16'hF800, 0);
    cycle(0, 1, 1, 16'h0801, 16'hF801, 1);
    cycle(1, 0, 0, 16'h0, 16'h0, 0);

    // randomized traffic
    pc = 16'h1000;
    for (int i = 0; i < 400; i++) begin
      logic r, f, iv, ordy;
      r    = ($urandom_range(0, 49) != 0);
      f    = ($urandom_range(0, 15) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      cycle(r, f, iv, pc, 16'($urandom), ordy);
      pc = pc + 16'd1;
    end
    cycle(1, 0, 0, 16'h0, 16'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the IF stage and the ID stage. It buffers up to DEPTH fetched {PC, instruction} pairs in order, so IF keeps fetching while ID stalls. A full queue back-pressures IF through its stall input. A flush from the branch/jump logic discards all buffered entries.

## Interface
- DEPTH, 4: number of entries; must be a power of two and at least 2.
- CW, $clog2(DEPTH)+1: width of the occupancy count (derived; do not override).
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  discards every entry; wired from jump_taken | branch_taken.
- in_valid  in  1  IF presents a fetched instruction this cycle.
- in_pc  in  16  PC of the presented instruction.
- in_instr  in  16  presented instruction word.
- in_ready  out  1  queue accepts a push; IF drives stall_if = ~in_ready.
- out_valid  out  1  head entry is valid.
- out_pc  out  16  PC of the head entry.
- out_instr  out  16  instruction word of the head entry.
- out_ready  in  1  ID consumes the head this cycle; ID holds it low on a load-use stall.
- count  out  CW  number of valid entries, 0..DEPTH.

## Operation
- Storage: a circular buffer of DEPTH {pc, instr} entries, plus rd_ptr and wr_ptr (log2(DEPTH) bits each) and count.
- Pointer wrap: both pointers increment modulo DEPTH and wrap DEPTH-1 -> 0 with no extra logic.
- Push: occurs when in_valid && in_ready && !flush.
  - Writes {in_pc, in_instr} at wr_ptr.
  - wr_ptr increments.
- Pop: occurs when out_valid && out_ready && !flush.
  - rd_ptr increments.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged.
- in_ready = (count != DEPTH).
  - in_ready is derived only from registered count.
  - A full queue refuses a push even if a pop occurs in the same cycle. This keeps out_ready off the path to in_ready.
- out_valid = (count != 0).
- Outputs when out_valid=1: out_pc and out_instr show the entry at rd_ptr.
- Outputs when out_valid=0: out_pc and out_instr are forced to 16'h0000, which is the NOP encoding.
- Flush priority:
  - flush outranks push and pop; both are ignored in the flush cycle.
  - Next cycle: count=0, rd_ptr=wr_ptr=0, out_valid=0, in_ready=1.
- Reset priority: rst_n=0 outranks flush, push and pop.
- Ordering: entries leave in exactly the order they were pushed. No reordering and no duplication.
- Storage contents are not reset; only pointers and count are. Stale data is never visible because the outputs are forced to zero when empty.

## Timing
- All state updates on the rising edge of clk.
- Reset:
  - On a clock edge with rst_n=0: count=0, rd_ptr=0, wr_ptr=0.
  - Outputs after reset: out_valid=0, out_pc=0, out_instr=0, in_ready=1, count=0.
  - Reset held across multiple cycles keeps this state; pushes are ignored.
  - Reset asserted mid-operation drops all entries, the same as a flush.
- Latency: a push at edge N is visible at out_* in the cycle after edge N. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Combinational paths:
  - count -> in_ready.
  - count, rd_ptr, storage -> out_*.
  - No combinational path from in_* or out_ready to any output.
- Boundary cases:
  - Empty with out_ready=1: no pop; count stays 0.
  - Full with in_valid=1: push refused; count stays DEPTH.
  - Full with a pop: count becomes DEPTH-1 and in_ready rises the next cycle.
  - flush in the same cycle as rst_n=0: reset governs; the result is identical.

## Test plan
- Reset then fill:
  - Stimulus: rst_n low for 2 cycles, then push pc=0..3 with instr=16'hA000+pc and out_ready=0.
  - Required: count goes 1,2,3,4; in_ready=0 after the 4th push; a 5th push (pc=4) is not stored.
- Drain order:
  - Stimulus: from full, out_ready=1 for 4 cycles.
  - Required: out_pc reads 0,1,2,3 with matching instr values; then out_valid=0 with out_pc=0 and out_instr=0.
- Streaming and wrap:
  - Stimulus: in_valid=1 and out_ready=1 for 20 cycles, pc incrementing.
  - Required: count stays 1 after the first cycle; out_pc trails in_pc by 1; output stays correct across 4 pointer wraps.
- Flush under activity:
  - Stimulus: count=3, then flush=1 together with in_valid=1 and out_ready=1.
  - Required: next cycle count=0, out_valid=0, in_ready=1; a subsequent push of pc=16'h0040 appears at the head one cycle later.
- Full with simultaneous pop:
  - Stimulus: count=4, in_valid=1 and out_ready=1.
  - Required: the pop happens and the push is refused; count=3 and in_ready=1 the next cycle.
- Reset mid-stream:
  - Stimulus: count=2, then rst_n=0 for 1 cycle with in_valid=1.
  - Required: count=0, out_valid=0, all outputs at their reset values, and no entry written.
